// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - N-master to 1-slave AXI-lite round-robin arbiter
// One whole read or write transaction is granted at a time and held until its response handshake.
module axi_lite_rr_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_MASTERS = 2,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_AW_ADDR,
  input  logic [NUM_MASTERS-1:0]            m_AW_VALID,
  output logic [NUM_MASTERS-1:0]            m_AW_READY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_W_DATA,
  input  logic [NUM_MASTERS*SW-1:0]         m_W_STRB,
  input  logic [NUM_MASTERS-1:0]            m_W_VALID,
  output logic [NUM_MASTERS-1:0]            m_W_READY,
  output logic [NUM_MASTERS-1:0]            m_B_VALID,
  input  logic [NUM_MASTERS-1:0]            m_B_READY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_AR_ADDR,
  input  logic [NUM_MASTERS-1:0]            m_AR_VALID,
  output logic [NUM_MASTERS-1:0]            m_AR_READY,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_R_DATA,
  output logic [NUM_MASTERS-1:0]            m_R_VALID,
  input  logic [NUM_MASTERS-1:0]            m_R_READY,
  output logic [ADDR_WIDTH-1:0]             s_AW_ADDR,
  output logic                              s_AW_VALID,
  input  logic                              s_AW_READY,
  output logic [DATA_WIDTH-1:0]             s_W_DATA,
  output logic [SW-1:0]                     s_W_STRB,
  output logic                              s_W_VALID,
  input  logic                              s_W_READY,
  input  logic                              s_B_VALID,
  output logic                              s_B_READY,
  output logic [ADDR_WIDTH-1:0]             s_AR_ADDR,
  output logic                              s_AR_VALID,
  input  logic                              s_AR_READY,
  input  logic [DATA_WIDTH-1:0]             s_R_DATA,
  input  logic                              s_R_VALID,
  output logic                              s_R_READY,
  output logic                              grant_valid,
  output logic [GW-1:0]                     grant_idx
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  localparam logic [GW:0] NM = (GW+1)'(NUM_MASTERS);

  state_t         state_q, state_d;
  logic [GW-1:0]  rr_ptr, rr_ptr_d;
  logic [GW-1:0]  grant_idx_d;
  logic           grant_valid_d;
  logic           aw_done, aw_done_d;
  logic           w_done, w_done_d;
  logic           ar_done, ar_done_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gsel;
  logic [GW-1:0]          pick_idx;
  logic [GW:0]            cand;
  logic [GW:0]            rr_next;

  logic [ADDR_WIDTH-1:0] aw_addr_a [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] ar_addr_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] w_data_a  [NUM_MASTERS];
  logic [SW-1:0]         w_strb_a  [NUM_MASTERS];

  logic wr_ph, rd_ph;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Unpack the flat per-master buses so the granted slice can be selected by index.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slices
    assign aw_addr_a[i] = m_AW_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign ar_addr_a[i] = m_AR_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_a[i]  = m_W_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb_a[i]  = m_W_STRB[i*SW +: SW];
    assign m_R_DATA[i*DATA_WIDTH +: DATA_WIDTH] = (rd_ph && gsel[i]) ? s_R_DATA : '0;
  end

  assign req   = m_AW_VALID | m_AR_VALID;
  assign wr_ph = (state_q == WR);
  assign rd_ph = (state_q == RD);
  assign gsel  = NUM_MASTERS'(1) << grant_idx;

  assign s_AW_VALID = wr_ph & m_AW_VALID[grant_idx] & ~aw_done;
  assign s_AW_ADDR  = wr_ph ? aw_addr_a[grant_idx] : '0;
  assign s_W_VALID  = wr_ph & m_W_VALID[grant_idx] & ~w_done;
  assign s_W_DATA   = wr_ph ? w_data_a[grant_idx] : '0;
  assign s_W_STRB   = wr_ph ? w_strb_a[grant_idx] : '0;
  assign s_B_READY  = wr_ph & m_B_READY[grant_idx];
  assign s_AR_VALID = rd_ph & m_AR_VALID[grant_idx] & ~ar_done;
  assign s_AR_ADDR  = rd_ph ? ar_addr_a[grant_idx] : '0;
  assign s_R_READY  = rd_ph & m_R_READY[grant_idx];

  assign m_AW_READY = gsel & {NUM_MASTERS{wr_ph & s_AW_READY & ~aw_done}};
  assign m_W_READY  = gsel & {NUM_MASTERS{wr_ph & s_W_READY & ~w_done}};
  assign m_B_VALID  = gsel & {NUM_MASTERS{wr_ph & s_B_VALID}};
  assign m_AR_READY = gsel & {NUM_MASTERS{rd_ph & s_AR_READY & ~ar_done}};
  assign m_R_VALID  = gsel & {NUM_MASTERS{rd_ph & s_R_VALID}};

  assign aw_hs = s_AW_VALID & s_AW_READY;
  assign w_hs  = s_W_VALID & s_W_READY;
  assign b_hs  = s_B_READY & s_B_VALID;
  assign ar_hs = s_AR_VALID & s_AR_READY;
  assign r_hs  = s_R_READY & s_R_VALID;

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    pick_idx = rr_ptr;
    cand     = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(k);
      if (cand >= NM) cand = cand - NM;
      if (req[cand[GW-1:0]]) pick_idx = cand[GW-1:0];
    end
  end

  always_comb begin
    rr_next = {1'b0, grant_idx} + (GW+1)'(1);
    if (rr_next >= NM) rr_next = '0;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ar_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr      <= rr_ptr_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
      aw_done     <= aw_done_d;
      w_done      <= w_done_d;
      ar_done     <= ar_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr;
    grant_idx_d   = grant_idx;
    grant_valid_d = grant_valid;
    aw_done_d     = aw_done;
    w_done_d      = w_done;
    ar_done_d     = ar_done;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = m_AW_VALID[pick_idx] ? WR : RD;
        end
      end
      WR: begin
        aw_done_d = aw_done | aw_hs;
        w_done_d  = w_done | w_hs;
        if (b_hs) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_next[GW-1:0];
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          ar_done_d     = 1'b0;
        end
      end
      RD: begin
        ar_done_d = ar_done | ar_hs;
        if (r_hs) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_next[GW-1:0];
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          ar_done_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
N-master to 1-slave AXI-lite arbiter. It replaces the externally steered two-master channel mux in front of the SRAM slave with internal round-robin arbitration. It grants one complete transaction at a time, read or write, and locks the grant until the response handshake finishes. The downstream port connects directly to the existing SRAM slave or to any other single-outstanding AXI-lite slave in the design.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width; W_STRB width is DATA_WIDTH/8.
- NUM_MASTERS, 2, number of upstream masters (>=1). GW = max(1, clog2(NUM_MASTERS)).

Ports:
- CLK  in  1  clock.
- RESETN  in  1  asynchronous active-low reset.
- m_AW_ADDR  in  NUM_MASTERS*ADDR_WIDTH  per-master write address, master i at slice i.
- m_AW_VALID / m_AW_READY  in / out  NUM_MASTERS  write-address handshake.
- m_W_DATA  in  NUM_MASTERS*DATA_WIDTH  write data.
- m_W_STRB  in  NUM_MASTERS*DATA_WIDTH/8  write strobes.
- m_W_VALID / m_W_READY  in / out  NUM_MASTERS  write-data handshake.
- m_B_VALID / m_B_READY  out / in  NUM_MASTERS  write response.
- m_AR_ADDR  in  NUM_MASTERS*ADDR_WIDTH  read address.
- m_AR_VALID / m_AR_READY  in / out  NUM_MASTERS  read-address handshake.
- m_R_DATA  out  NUM_MASTERS*DATA_WIDTH  read data.
- m_R_VALID / m_R_READY  out / in  NUM_MASTERS  read-data handshake.
- s_AW_ADDR, s_AW_VALID / s_AW_READY  out, out / in  ADDR_WIDTH, 1 / 1  to slave.
- s_W_DATA, s_W_STRB, s_W_VALID / s_W_READY  out / in  DATA_WIDTH, DATA_WIDTH/8, 1 / 1.
- s_B_VALID / s_B_READY  in / out  1.
- s_AR_ADDR, s_AR_VALID / s_AR_READY  out, out / in  ADDR_WIDTH, 1 / 1.
- s_R_DATA, s_R_VALID / s_R_READY  in, in / out  DATA_WIDTH, 1 / 1.
- grant_valid  out  1  a transaction is locked.
- grant_idx  out  GW  index of the locked master.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0.
  - aw_done, w_done, ar_done cleared.
  - All m_* and s_* outputs 0.
  - An in-flight slave transaction is abandoned; the slave is reset by the same RESETN.
- Request vector: req[i] = m_AW_VALID[i] | m_AR_VALID[i].
- FSM states: IDLE, WR, RD.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr with wrap-around.
  - Register it into grant_idx and set grant_valid.
  - Next state is WR if that master has m_AW_VALID set, otherwise RD. Write wins when a master presents both.
  - No m_* or s_* handshake signal is asserted in IDLE; arbitration costs exactly 1 cycle.
- WR:
  - s_AW_VALID = m_AW_VALID[g] & ~aw_done; s_W_VALID = m_W_VALID[g] & ~w_done. Address, data and strobes come from slice g.
  - m_AW_READY[g] = s_AW_READY & ~aw_done; m_W_READY[g] = s_W_READY & ~w_done.
  - AW and W are independent: either may complete first or both in the same cycle. Each sets its done flag on handshake.
  - m_B_VALID[g] = s_B_VALID; s_B_READY = m_B_READY[g].
  - On the B handshake: state=IDLE, rr_ptr=(g+1) mod NUM_MASTERS, flags cleared, grant_valid=0.
- RD:
  - s_AR_VALID = m_AR_VALID[g] & ~ar_done; m_AR_READY[g] = s_AR_READY & ~ar_done; ar_done set on handshake.
  - m_R_VALID[g] = s_R_VALID; m_R_DATA slice g = s_R_DATA; s_R_READY = m_R_READY[g].
  - On the R handshake: return to IDLE, update rr_ptr, clear flags.
- Non-granted masters see all READY/VALID = 0 and R_DATA slice = 0.
- Off-phase s_* signals are 0: AR signals in WR, AW/W signals in IDLE and RD.
- Grant is held regardless of slave or master backpressure; there is no timeout.
- A master dropping VALID before its handshake (protocol violation) does not release the grant.
- Minimum spacing between back-to-back transactions is one IDLE cycle.
- rr_ptr only advances on completion. A persistently requesting master gets at most one transaction per full rotation while others are requesting.
- NUM_MASTERS=1: the arbiter degenerates to a pass-through with one IDLE cycle per transaction; rr_ptr stays 0.

Test Plan:
- Single read: master 0 AR_ADDR=0x8000_0000; slave returns R_DATA=0x1122334455667788 → grant_idx=0, s_AR_VALID rises 1 cycle after m_AR_VALID; m_R_DATA slice 0 = value; back to IDLE the cycle after the R handshake.
- Contention: masters 0 and 1 both assert AR in the same cycle, rr_ptr=0 → master 0 served first, then master 1; master 1 m_AR_READY stays 0 until its grant.
- Fairness: NUM_MASTERS=3, all requesting continuously → grant order 0,1,2,0,1,2; rr_ptr after each completion = 1,2,0,...
- Write ordering: master 1 asserts W 3 cycles before AW, STRB=0x0F → W handshake first, AW later; exactly one B routed to master 1; no duplicate slave handshake.
- Backpressure: m_R_READY held low 5 cycles after s_R_VALID → s_R_READY=0 for those cycles; data stable; grant unchanged.
- Reset mid-write, after the AW handshake but before B → all outputs 0 immediately; after release, a new request is arbitrated from rr_ptr=0.
